// File: rtl/norm_arb.sv
// rtl/norm_arb.sv - round-robin arbiter sharing one leading-zero counter and normaliser
//
// norm_lzc : leading-zero counter, returns W for an all-zero input.
//   data_i  in  W      value to scan
//   cnt_o   out CNT_W  number of leading zeros
//
// norm_arb : N requesters share one norm_lzc and one left-shifter; one registered result slot.
//   clk          in   1      clock, rising edge
//   nreset       in   1      asynchronous active-low reset
//   req_valid_i  in   N      per-requester valid
//   req_data_i   in   N*W    mantissas, requester k at [k*W +: W]
//   req_exp_i    in   N*E    exponents, requester k at [k*E +: E]
//   req_ready_o  out  N      one-hot (or zero) accept
//   res_valid_o  out  1      result slot occupied
//   res_ready_i  in   1      consumer takes the result
//   res_id_o     out  ID_W   requester that produced the result
//   res_data_o   out  W      normalised mantissa
//   res_exp_o    out  E      adjusted exponent
//   res_cnt_o    out  CNT_W  leading-zero count
//   res_zero_o   out  1      input mantissa was zero
//   res_uf_o     out  1      exponent underflow, result flushed to zero

module norm_lzc #(
  parameter int W     = 16,
  parameter int CNT_W = $clog2(W+1)
) (
  input  logic [W-1:0]     data_i,
  output logic [CNT_W-1:0] cnt_o
);
  // Scanning upward lets the highest set bit overwrite earlier hits.
  always_comb begin
    cnt_o = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) cnt_o = CNT_W'(W - 1 - i);
    end
  end
endmodule

module norm_arb #(
  parameter int N = 2,
  parameter int W = 16,
  parameter int E = 8,
  localparam int CNT_W = $clog2(W+1),
  localparam int ID_W  = $clog2(N)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [N-1:0]     req_valid_i,
  input  logic [N*W-1:0]   req_data_i,
  input  logic [N*E-1:0]   req_exp_i,
  output logic [N-1:0]     req_ready_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ID_W-1:0]  res_id_o,
  output logic [W-1:0]     res_data_o,
  output logic [E-1:0]     res_exp_o,
  output logic [CNT_W-1:0] res_cnt_o,
  output logic             res_zero_o,
  output logic             res_uf_o
);
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [W-1:0]     data_q, data_d;
  logic [E-1:0]     exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             uf_q, uf_d;

  logic             found;
  logic [ID_W-1:0]  gnt;
  logic             free;
  logic             accept;
  logic [W-1:0]     sel_data;
  logic [E-1:0]     sel_exp;
  logic [CNT_W-1:0] lz;

  // First valid requester at or after ptr, wrapping modulo N.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_q) + off) % N;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gnt   = ID_W'(idx);
      end
    end
  end

  assign free        = !valid_q | res_ready_i;
  assign accept      = found & free;
  assign req_ready_o = accept ? (N'(1) << gnt) : '0;

  // Only the granted lane reaches the shared counter and shifter.
  assign sel_data = req_data_i[int'(gnt)*W +: W];
  assign sel_exp  = req_exp_i[int'(gnt)*E +: E];

  norm_lzc #(.W(W), .CNT_W(CNT_W)) u_lzc (
    .data_i (sel_data),
    .cnt_o  (lz)
  );

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    id_d    = id_q;
    data_d  = data_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
    if (accept) begin
      ptr_d   = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
      valid_d = 1'b1;
      id_d    = gnt;
      cnt_d   = lz;
      zero_d  = 1'b0;
      uf_d    = 1'b0;
      data_d  = '0;
      exp_d   = '0;
      if (sel_data == '0) begin
        zero_d = 1'b1;
      end else if (int'(sel_exp) <= int'(lz)) begin
        uf_d = 1'b1;
      end else begin
        // lz < W and sel_exp > lz here, so neither the shift nor the subtract overflows.
        data_d = sel_data << lz;
        exp_d  = sel_exp - E'(lz);
      end
    end else if (res_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
    end
  end

  assign res_valid_o = valid_q;
  assign res_id_o    = id_q;
  assign res_data_o  = data_q;
  assign res_exp_o   = exp_q;
  assign res_cnt_o   = cnt_q;
  assign res_zero_o  = zero_q;
  assign res_uf_o    = uf_q;
endmodule

// File: doc/norm_arb.md
Name: norm_arb

Overview:
- Round-robin scheduler that shares one `lzc` instance and one left-shifter between N requesters, e.g. the add and mul result paths.
- Each requester hands in an unnormalised mantissa and its exponent. The block returns the normalised mantissa, the adjusted exponent, the leading-zero count and zero/underflow flags.
- The result sits in a single registered output slot with a valid/ready handshake.
- It sits between the BFloat16 arithmetic stages and the rounding/pack stage.

Parameters:
- N, 2, number of requesters (N >= 2).
- W, 16, mantissa width; also the width of the shared `lzc` instance.
- E, 8, exponent width.
- Derived, not overridable: CNT_W = $clog2(W+1); ID_W = $clog2(N).

Ports:
- clk  in  1  clock, all state on rising edge.
- nreset  in  1  asynchronous, active-low reset.
- req_valid_i  in  N  per-requester request valid.
- req_data_i  in  N*W  mantissas; requester k occupies bits [k*W +: W].
- req_exp_i  in  N*E  exponents; requester k occupies bits [k*E +: E].
- req_ready_o  out  N  per-requester accept; at most one bit set per cycle.
- res_valid_o  out  1  output slot holds a result.
- res_ready_i  in  1  consumer accepts the result.
- res_id_o  out  ID_W  index of the requester that produced the result.
- res_data_o  out  W  normalised mantissa.
- res_exp_o  out  E  adjusted exponent.
- res_cnt_o  out  CNT_W  leading-zero count reported by `lzc`.
- res_zero_o  out  1  input mantissa was zero.
- res_uf_o  out  1  underflow; result flushed to zero.

Behaviour:
- Reset (async assert, sync release): res_valid_o=0; res_id_o, res_data_o, res_exp_o, res_cnt_o, res_zero_o, res_uf_o all 0; round-robin pointer ptr=0.
- Reset during a held result drops that result.
- Slot free condition: free = !res_valid_o | res_ready_i.
- Grant: g = first k with req_valid_i[k]=1, searching ptr, ptr+1, … modulo N.
  - req_ready_o[g] = free; every other req_ready_o bit = 0.
  - If no request is valid, req_ready_o = 0.
  - req_ready_o is combinational from req_valid_i, ptr, res_valid_o and res_ready_i.
- Accept: req_valid_i[g] & req_ready_o[g] at a rising edge.
  - Next cycle, res_valid_o=1 and all result fields come from requester g.
  - Latency is 1 cycle.
  - ptr <= (g+1) mod N. With no accept, ptr is unchanged.
- Drain: res_valid_o & res_ready_i with no accept in the same cycle gives res_valid_o=0 next cycle.
  - Data fields keep their last value.
- Simultaneous drain and accept: the slot is overwritten and res_valid_o stays 1. Throughput is one result per cycle.
- Backpressure: while res_valid_o=1 and res_ready_i=0:
  - all result outputs are stable;
  - req_ready_o = 0;
  - ptr is frozen.
- Arithmetic, with d = req_data_i[g], x = req_exp_i[g], c = lzc(d):
  - d == 0 (c == W): res_zero_o=1, res_uf_o=0, res_data_o=0, res_exp_o=0, res_cnt_o=W.
  - d != 0 and x <= c (unsigned compare): res_uf_o=1, res_zero_o=0, res_data_o=0, res_exp_o=0, res_cnt_o=c.
  - Otherwise: res_data_o = d << c (MSB always 1), res_exp_o = x - c, both flags 0, res_cnt_o = c.
  - c is at most W-1 here, so the shift never exceeds W-1. x - c never wraps, because x > c.
- Only the granted requester's fields feed `lzc`. Non-granted inputs have no effect on any output.
- Requester rules:
  - A requester holds valid and its data stable until accepted.
  - Dropping valid before it is accepted is legal; the request is simply withdrawn.

Test Plan:
1. Single request, N=2, W=16, E=8, res_ready_i=1: requester 0 sends d=0x0001, x=20.
   Next cycle: res_valid_o=1, res_id_o=0, res_data_o=0x8000, res_exp_o=5, res_cnt_o=15, res_zero_o=0, res_uf_o=0.
2. Zero input: requester 1 sends d=0x0000, x=100.
   Result: res_zero_o=1, res_data_o=0, res_exp_o=0, res_cnt_o=16, res_id_o=1.
3. Underflow boundary, single requester:
   - d=0x00FF, x=8: res_uf_o=1, res_data_o=0, res_exp_o=0, res_cnt_o=8.
   - d=0x00FF, x=9: res_data_o=0xFF00, res_exp_o=1, res_uf_o=0.
4. Fairness: both requesters held valid for 6 cycles, res_ready_i=1.
   - req_ready_o sequence is 01, 10, 01, 10, …; res_id_o sequence is 0, 1, 0, 1, 0, 1.
   - One result per cycle, with no bubbles.
5. Backpressure: a result is held and res_ready_i=0 for 3 cycles while both requesters are valid.
   - All res_* stable and req_ready_o=00 throughout.
   - Raise res_ready_i: the next grant is accepted that same cycle and res_valid_o stays 1.
6. Reset mid-operation: pull nreset low while res_valid_o=1.
   - res_valid_o=0 immediately (async).
   - After release, both requesters valid gives the first grant to requester 0.
